// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : shared sizes, sample type and bit-reverse helper for the FFT path
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_PTS      = 16;
   localparam int FFT_PTS_LOG2 = 4;
   localparam int FFT_W        = 8;

   typedef struct packed {
      logic signed [FFT_W-1:0] re;
      logic signed [FFT_W-1:0] im;
   } cplx_t;

   function automatic logic [FFT_PTS_LOG2-1:0] bitrev(input logic [FFT_PTS_LOG2-1:0] a);
      logic [FFT_PTS_LOG2-1:0] r;
      for (int i = 0; i < FFT_PTS_LOG2; i++) begin
         r[i] = a[FFT_PTS_LOG2-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pingpong_ram : 2-bank flop array, one write port, one async read port
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int W  = 2 * FFT_W,
   parameter int AW = FFT_PTS_LOG2
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          wbank_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          rbank_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   localparam int DEPTH = 1 << AW;

   // Contents are never reset; readers only look at banks holding a full frame.
   logic [W-1:0] mem_q [2*DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[{wbank_i, waddr_i}] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[{rbank_i, raddr_i}];

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_bitrev_reorder : bit-reversed FFT bins in, natural-order valid/ready out
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int n        = FFT_W,
   parameter int PTS_LOG2 = FFT_PTS_LOG2
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [n-1:0]        in_r,
   input  logic [n-1:0]        in_im,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [n-1:0]        out_r,
   output logic [n-1:0]        out_im,
   output logic [PTS_LOG2-1:0] out_idx,
   output logic                out_last,
   output logic                overrun
);

   localparam logic [PTS_LOG2-1:0] c_LAST = '1;

   logic [PTS_LOG2-1:0] wr_cnt_q, wr_cnt_d;
   logic                wr_bank_q, wr_bank_d;
   logic                rd_busy_q, rd_busy_d;
   logic [PTS_LOG2-1:0] rd_cnt_q, rd_cnt_d;
   logic                overrun_q, overrun_d;

   logic                w_pop;
   logic                w_last_pop;
   logic                w_frame_done;
   logic                w_drain_free;
   logic                w_swap;
   logic                w_drop;
   logic [2*n-1:0]      w_rdata;

   assign w_pop        = rd_busy_q & out_ready;
   assign w_last_pop   = w_pop & (rd_cnt_q == c_LAST);
   assign w_frame_done = in_valid & (wr_cnt_q == c_LAST);
   // Final drain handshake frees the bank on the same edge a new frame lands.
   assign w_drain_free = ~rd_busy_q | w_last_pop;
   assign w_swap       = w_frame_done & w_drain_free;
   assign w_drop       = w_frame_done & ~w_drain_free;

   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q ^ w_swap;
      rd_busy_d = rd_busy_q;
      rd_cnt_d  = rd_cnt_q;
      overrun_d = overrun_q | w_drop;
      if (in_valid) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (w_swap) begin
         rd_busy_d = 1'b1;
         rd_cnt_d  = '0;
      end else if (w_pop) begin
         if (rd_cnt_q == c_LAST) begin
            rd_busy_d = 1'b0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_busy_q <= 1'b0;
         rd_cnt_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_busy_q <= rd_busy_d;
         rd_cnt_q  <= rd_cnt_d;
         overrun_q <= overrun_d;
      end
   end

   fft_pingpong_ram #(
      .W  (2 * n),
      .AW (PTS_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (in_valid),
      .wbank_i (wr_bank_q),
      .waddr_i (bitrev(wr_cnt_q)),
      .wdata_i ({in_r, in_im}),
      .rbank_i (~wr_bank_q),
      .raddr_i (rd_cnt_q),
      .rdata_o (w_rdata)
   );

   assign out_valid        = rd_busy_q;
   assign out_idx          = rd_cnt_q;
   assign out_last         = rd_busy_q & (rd_cnt_q == c_LAST);
   assign {out_r, out_im}  = rd_busy_q ? w_rdata : '0;
   assign overrun          = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder : directed frames checked against a frame-queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_r = '0;
   logic [7:0] in_im = '0;
   logic       out_valid;
   logic [7:0] out_r;
   logic [7:0] out_im;
   logic [3:0] out_idx;
   logic       out_last;
   logic       overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fft_bitrev_reorder #(.n(8), .PTS_LOG2(4)) dut (
      .clk       (clk),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_r      (in_r),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .overrun   (overrun)
   );

   typedef struct {
      logic [3:0] idx;
      logic [7:0] r;
      logic [7:0] im;
   } bin_t;

   bin_t        exp_q[$];
   logic [15:0] frame_buf[$];
   logic        ovr_m = 1'b0;
   logic [7:0]  got_r[$];
   int          valid_cycles = 0;
   logic [7:0]  seq[16] = '{8'd0, 8'd8, 8'd4, 8'd12, 8'd2, 8'd10, 8'd6, 8'd14,
                            8'd1, 8'd9, 8'd5, 8'd13, 8'd3, 8'd11, 8'd7, 8'd15};

   function automatic logic [3:0] rev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a completed frame is accepted only if no bins remain to deliver
   // after this cycle's handshake; otherwise it is lost and overrun latches.
   bin_t b_m;
   always @(posedge clk or posedge clear) begin
      if (clear) begin
         exp_q.delete();
         frame_buf.delete();
         ovr_m = 1'b0;
      end else begin
         if (exp_q.size() > 0 && out_ready) exp_q.delete(0);
         if (in_valid) begin
            frame_buf.push_back({in_r, in_im});
            if (frame_buf.size() == 16) begin
               if (exp_q.size() == 0) begin
                  for (int j = 0; j < 16; j++) begin
                     b_m.idx = j[3:0];
                     {b_m.r, b_m.im} = frame_buf[rev4(j[3:0])];
                     exp_q.push_back(b_m);
                  end
               end else begin
                  ovr_m = 1'b1;
               end
               frame_buf.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!clear) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
         chk("overrun", {31'd0, overrun}, {31'd0, ovr_m});
         if (exp_q.size() > 0) begin
            chk("out_idx", {28'd0, out_idx}, {28'd0, exp_q[0].idx});
            chk("out_r", {24'd0, out_r}, {24'd0, exp_q[0].r});
            chk("out_im", {24'd0, out_im}, {24'd0, exp_q[0].im});
            chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].idx == 4'hF});
         end
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) got_r.push_back(out_r);
      end
   end

   task automatic step(input logic iv, input logic [7:0] r, input logic rdy);
      in_valid  = iv;
      in_r      = r;
      in_im     = -r;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] base, input logic rdy);
      for (int k = 0; k < 16; k++) step(1'b1, base + 8'(k), rdy);
   endtask

   task automatic idle(input int cycles, input logic rdy);
      for (int c = 0; c < cycles; c++) step(1'b0, 8'd0, rdy);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #1;
      chk("clr_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_last", {31'd0, out_last}, 32'd0);
      chk("clr_overrun", {31'd0, overrun}, 32'd0);
      chk("clr_idx", {28'd0, out_idx}, 32'd0);
      chk("clr_r", {24'd0, out_r}, 32'd0);
      chk("clr_im", {24'd0, out_im}, 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset asserted between edges must act at once
      #2;
      do_clear();
      idle(5, 1'b1);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Single frame: bin j carries sample bitrev(j)
      got_r.delete();
      valid_cycles = 0;
      send_frame(8'd0, 1'b1);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_r", {24'd0, out_r}, 32'd0);
      idle(17, 1'b1);
      chk("s2_count", got_r.size(), 32'd16);
      chk("s2_cycles", valid_cycles, 32'd16);
      for (int i = 0; i < 16 && i < got_r.size(); i++) chk("s2_seq", {24'd0, got_r[i]}, {24'd0, seq[i]});

      // Three back-to-back frames
      got_r.delete();
      valid_cycles = 0;
      send_frame(8'd0, 1'b1);
      send_frame(8'd16, 1'b1);
      send_frame(8'd32, 1'b1);
      idle(17, 1'b1);
      chk("s3_count", got_r.size(), 32'd48);
      chk("s3_cycles", valid_cycles, 32'd48);
      chk("s3_overrun", {31'd0, overrun}, 32'd0);
      if (got_r.size() >= 48) begin
         chk("s3_f2_b1", {24'd0, got_r[17]}, 32'd24);
         chk("s3_f3_b15", {24'd0, got_r[47]}, 32'd47);
      end

      // Backpressure 1,0,0 pattern
      got_r.delete();
      send_frame(8'd48, 1'b1);
      for (int c = 0; c < 50; c++) step(1'b0, 8'd0, (c % 3) == 0);
      idle(2, 1'b1);
      chk("s4_count", got_r.size(), 32'd16);
      for (int i = 0; i < 16 && i < got_r.size(); i++) chk("s4_seq", {24'd0, got_r[i]}, {24'd0, 8'd48 + seq[i]});

      // Overrun: frame 2 lands while frame 1 is still undelivered
      got_r.delete();
      send_frame(8'd64, 1'b0);
      send_frame(8'd80, 1'b0);
      chk("s5_overrun_set", {31'd0, overrun}, 32'd1);
      idle(20, 1'b1);
      chk("s5_count1", got_r.size(), 32'd16);
      if (got_r.size() >= 2) chk("s5_f1_b1", {24'd0, got_r[1]}, 32'd72);
      send_frame(8'd96, 1'b1);
      idle(17, 1'b1);
      chk("s5_count2", got_r.size(), 32'd32);
      if (got_r.size() >= 32) chk("s5_f3_b1", {24'd0, got_r[17]}, 32'd104);
      chk("s5_overrun_sticky", {31'd0, overrun}, 32'd1);
      do_clear();

      // Clear mid-write and mid-drain
      for (int k = 0; k < 7; k++) step(1'b1, 8'(k + 100), 1'b1);
      do_clear();
      send_frame(8'd0, 1'b1);
      idle(5, 1'b1);
      chk("s6_idx5", {28'd0, out_idx}, 32'd5);
      do_clear();
      got_r.delete();
      send_frame(8'd0, 1'b1);
      idle(17, 1'b1);
      chk("s6_count", got_r.size(), 32'd16);
      for (int i = 0; i < 16 && i < got_r.size(); i++) chk("s6_seq", {24'd0, got_r[i]}, {24'd0, seq[i]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Downstream stage of fft_16point. It accepts the 16 complex FFT output bins, which arrive one per clock in bit-reversed order, and stores them in a ping-pong buffer. It then re-emits each frame in natural bin order (X0..X15) over a valid/ready stream. This gives back-end consumers such as the magnitude and peak-detect stages an in-order, stallable interface, while the FFT itself never stalls.

Parameters:
n, 8, bit width of each real and imaginary sample (two's complement); matches fft_16point.
PTS_LOG2, 4, log2 of frame length; 16 points. Only 4 is verified.

Ports:
clk  input  1  system clock, rising edge.
clear  input  1  asynchronous, active-high reset.
in_valid  input  1  in_r/in_im carry an FFT output sample this cycle.
in_r  input  n  real part of FFT output (y_r of fft_16point).
in_im  input  n  imaginary part of FFT output (y_im of fft_16point).
out_valid  output  1  out_r/out_im/out_idx hold a valid bin.
out_ready  input  1  consumer accepts the bin when out_valid&&out_ready.
out_r  output  n  real part of bin out_idx.
out_im  output  n  imaginary part of bin out_idx.
out_idx  output  PTS_LOG2  natural bin index, 0..15.
out_last  output  1  high with bin 15 of a frame.
overrun  output  1  sticky: a complete input frame was dropped.

Behaviour:
- Reset: clear asserted forces the following, immediately and regardless of clk:
  - out_valid=0, out_last=0, overrun=0, out_idx=0, out_r=0, out_im=0.
  - wr_cnt=0, wr_bank=0, rd_busy=0, rd_cnt=0.
  - Buffer contents are not cleared; they are don't-care.
- Clear during a frame discards both the partial write and any pending read. After clear deasserts, the first sample taken is bin-order position 0 of a new frame.
- Storage: two banks of 16 entries, each entry 2*n bits, built from flops. wr_bank selects the fill bank; the other bank is the drain bank.
- Write: each cycle with in_valid=1, {in_r,in_im} is stored at mem[wr_bank][bitrev(wr_cnt)], then wr_cnt increments mod 16. in_valid=0 holds wr_cnt; gaps are allowed.
- Frame completion happens on a write with wr_cnt==15:
  - Drain bank free means rd_busy==0, or the last drain handshake (rd_cnt==15 && out_valid && out_ready) occurs in the same cycle. In that case, on the same edge: wr_bank toggles, rd_busy=1, rd_cnt=0.
  - Drain bank not free: the frame is dropped, overrun is set (sticky until clear), wr_bank is unchanged and wr_cnt wraps to 0. The next frame overwrites the dropped one.
- Read:
  - out_valid = rd_busy (registered).
  - out_idx = rd_cnt.
  - {out_r,out_im} = mem[~wr_bank][rd_cnt].
  - out_last = rd_busy && rd_cnt==15.
  - On out_valid&&out_ready: rd_cnt increments. When rd_cnt==15, rd_busy clears instead, unless a new frame completes in the same cycle, in which case rd_busy stays 1 and rd_cnt goes to 0.
  - With out_ready low, outputs hold stable.
- Latency: the last sample of a frame is written at edge t. out_valid rises at edge t, so bin 0 is visible in the cycle after edge t. With out_ready held at 1, bins emit back-to-back over 16 cycles.
- Throughput: continuous 1 sample/cycle input with out_ready=1 never overruns.
- No arithmetic is applied. Data passes through bit-exact, with no sign extension.

Decomposition:
- fft_pkg holds:
  - FFT_PTS=16 and FFT_PTS_LOG2=4.
  - A bitrev function of width FFT_PTS_LOG2.
  - The complex sample struct {re, im} of width n.
  fft_16point and this block share the package.
- One natural sub-module is fft_pingpong_ram: a 2-bank by 16-entry flop array with one write port (bank, addr) and one asynchronous read port.
- The control logic (wr_cnt, rd_cnt, rd_busy, wr_bank, overrun) stays in the top module.

Test Plan:
1. Reset values: hold clear=1 mid-clock -> all outputs 0 immediately, overrun=0; release and idle 5 cycles -> out_valid stays 0.
2. Single frame reorder: in_r=k, in_im=-k for k=0..15, in_valid=1, out_ready=1 -> next cycle out_r emits 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_idx 0..15; out_im is the negated sequence; out_last only on the 16th bin; out_valid drops the cycle after.
3. Back-to-back frames: 3 continuous frames (in_r=k, then k+16, then k+32), out_ready=1 -> 48 contiguous output bins, no gaps, overrun=0.
4. Backpressure: out_ready toggles 1,0,0,1,... during drain -> out_* hold stable while out_ready=0; every bin is delivered once and in order.
5. Overrun: out_ready=0 for a whole frame 1 drain while frame 2 completes -> overrun=1; after out_ready=1, only frame 1's 16 bins appear; frame 3 then drains normally, and overrun stays 1 until clear.
6. Mid-frame reset: clear pulses after 7 input samples and again during a drain at out_idx=5 -> out_valid=0 at once; a fresh 16-sample frame afterwards reorders correctly per scenario 2.
